// File: rtl/rpn_stack_controller.sv
// RPN calculator stack controller driving an external ALU.
// Define RPN_STACK_DUP_EN to enable the DUP command (cmd 11).
module rpn_stack_controller #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] top,
  output logic [3:0]       depth,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             error
);

  localparam int AW = (DEPTH > 4) ? 3 : (DEPTH > 2) ? 2 : 1;
  localparam logic [3:0] LP_FULL = 4'(DEPTH);

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_OP   = 2'b01;
  localparam logic [1:0] CMD_DROP = 2'b10;
  localparam logic [1:0] CMD_DUP  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [3:0]       r_depth;
  logic [1:0]       r_aluOp;
  logic [3:0]       r_flags;
  logic             r_error;

  logic [AW-1:0]    w_topIdx;
  logic [AW-1:0]    w_nosIdx;
  logic [AW-1:0]    w_pushIdx;
  logic             w_hasTop;
  logic             w_hasTwo;
  logic             w_isFull;

  logic             w_doPush;
  logic [WIDTH-1:0] w_pushData;
  logic             w_doDrop;
  logic             w_startOp;
  logic             w_cmdLegal;
  logic             w_cmdIllegal;

  // Indices wrap modulo 2**AW, which is exact because depth never exceeds DEPTH.
  assign w_topIdx  = r_depth[AW-1:0] - AW'(1);
  assign w_nosIdx  = r_depth[AW-1:0] - AW'(2);
  assign w_pushIdx = r_depth[AW-1:0];
  assign w_hasTop  = (r_depth != 4'd0);
  assign w_hasTwo  = (r_depth >= 4'd2);
  assign w_isFull  = (r_depth >= LP_FULL);

  always_comb begin
    w_nextState  = r_state;
    w_doPush     = 1'b0;
    w_pushData   = data_in;
    w_doDrop     = 1'b0;
    w_startOp    = 1'b0;
    w_cmdLegal   = 1'b0;
    w_cmdIllegal = 1'b0;
    case (r_state)
      IDLE: begin
        if (enter) begin
          case (cmd)
            CMD_PUSH: begin
              if (!w_isFull) begin
                w_doPush   = 1'b1;
                w_cmdLegal = 1'b1;
              end else begin
                w_cmdIllegal = 1'b1;
              end
            end
            CMD_OP: begin
              if (w_hasTwo) begin
                w_startOp   = 1'b1;
                w_cmdLegal  = 1'b1;
                w_nextState = EXEC;
              end else begin
                w_cmdIllegal = 1'b1;
              end
            end
            CMD_DROP: begin
              if (w_hasTop) begin
                w_doDrop   = 1'b1;
                w_cmdLegal = 1'b1;
              end else begin
                w_cmdIllegal = 1'b1;
              end
            end
            CMD_DUP: begin
`ifdef RPN_STACK_DUP_EN
              if (w_hasTop && !w_isFull) begin
                w_doPush   = 1'b1;
                w_pushData = r_stack[w_topIdx];
                w_cmdLegal = 1'b1;
              end else begin
                w_cmdIllegal = 1'b1;
              end
`else
              w_cmdIllegal = 1'b1;
`endif
            end
            default: w_cmdIllegal = 1'b1;
          endcase
        end
      end
      EXEC:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Reset during EXEC wins, so an in-flight result is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_depth <= 4'd0;
      r_aluOp <= 2'b00;
      r_flags <= 4'd0;
      r_error <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      if (w_doPush) begin
        r_stack[w_pushIdx] <= w_pushData;
        r_depth            <= r_depth + 4'd1;
      end
      if (w_doDrop) begin
        r_depth <= r_depth - 4'd1;
      end
      if (w_startOp) begin
        r_aluOp <= op_sel;
      end
      if (r_state == EXEC) begin
        r_stack[w_nosIdx] <= alu_result;
        r_flags           <= alu_flags;
        r_depth           <= r_depth - 4'd1;
      end
      if (w_cmdIllegal) begin
        r_error <= 1'b1;
      end else if (w_cmdLegal) begin
        r_error <= 1'b0;
      end
    end
  end

  assign alu_a     = w_hasTwo ? r_stack[w_nosIdx] : '0;
  assign alu_b     = w_hasTwo ? r_stack[w_topIdx] : '0;
  assign alu_op    = r_aluOp;
  assign alu_valid = (r_state == EXEC);
  assign top       = w_hasTop ? r_stack[w_topIdx] : '0;
  assign depth     = r_depth;
  assign flags     = r_flags;
  assign busy      = (r_state != IDLE);
  assign error     = r_error;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// Directed self-checking bench for rpn_stack_controller with a small add/sub/and/or ALU.
// Expectations follow RPN_STACK_DUP_EN when the macro is defined for the build.
module tb_rpn_stack_controller;

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_OP   = 2'b01;
  localparam logic [1:0] CMD_DROP = 2'b10;
  localparam logic [1:0] CMD_DUP  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic [1:0]  cmd;
  logic [15:0] data_in;
  logic [1:0]  op_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_valid;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic [15:0] top;
  logic [3:0]  depth;
  logic [3:0]  flags;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;
  int validCount = 0;

  logic [16:0] aluWide;

  rpn_stack_controller #(.WIDTH(16), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enter      (enter),
    .cmd        (cmd),
    .data_in    (data_in),
    .op_sel     (op_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_valid  (alu_valid),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .top        (top),
    .depth      (depth),
    .flags      (flags),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  // External ALU: 00 add, 01 sub (carry = no borrow), 10 and, 11 or.
  always_comb begin
    aluWide    = 17'd0;
    alu_flags  = 4'd0;
    case (alu_op)
      2'b00:   aluWide = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   aluWide = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      2'b10:   aluWide = {1'b0, alu_a & alu_b};
      default: aluWide = {1'b0, alu_a | alu_b};
    endcase
    alu_result   = aluWide[15:0];
    alu_flags[3] = aluWide[15];
    alu_flags[2] = (aluWide[15:0] == 16'd0);
    alu_flags[1] = (alu_op[1] == 1'b0) ? aluWide[16] : 1'b0;
    if (alu_op == 2'b00) begin
      alu_flags[0] = (alu_a[15] == alu_b[15]) && (aluWide[15] != alu_a[15]);
    end else if (alu_op == 2'b01) begin
      alu_flags[0] = (alu_a[15] != alu_b[15]) && (aluWide[15] != alu_a[15]);
    end
  end

  always @(negedge clk) begin
    if (alu_valid === 1'b1) validCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [15:0] d, input logic [1:0] o);
    @(negedge clk);
    cmd     = c;
    data_in = d;
    op_sel  = o;
    enter   = 1'b1;
    @(posedge clk);
    #1;
    enter   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    enter   = 1'b0;
    cmd     = 2'b00;
    data_in = 16'd0;
    op_sel  = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_depth", 32'(depth), 32'd0);
    checkOutput("rst_top", 32'(top), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(alu_valid), 32'd0);
    checkOutput("rst_aluop", 32'(alu_op), 32'd0);
    checkOutput("rst_alua", 32'(alu_a), 32'd0);
    reset = 1'b0;

    // Underflowing OP from empty
    applyStimulus(CMD_OP, 16'd0, 2'b01);
    checkOutput("uf_error", 32'(error), 32'd1);
    checkOutput("uf_busy", 32'(busy), 32'd0);
    checkOutput("uf_depth", 32'(depth), 32'd0);
    tick();
    checkOutput("uf_validcnt", 32'(validCount), 32'd0);
    checkOutput("uf_aluop", 32'(alu_op), 32'd0);

    // 5 + 3 with adder
    applyStimulus(CMD_PUSH, 16'd5, 2'b00);
    checkOutput("p5_depth", 32'(depth), 32'd1);
    checkOutput("p5_top", 32'(top), 32'd5);
    checkOutput("p5_error", 32'(error), 32'd0);
    checkOutput("p5_alub", 32'(alu_b), 32'd0);
    applyStimulus(CMD_PUSH, 16'd3, 2'b00);
    checkOutput("p3_depth", 32'(depth), 32'd2);
    checkOutput("p3_alua", 32'(alu_a), 32'd5);
    checkOutput("p3_alub", 32'(alu_b), 32'd3);
    applyStimulus(CMD_OP, 16'd0, 2'b00);
    checkOutput("add_busy", 32'(busy), 32'd1);
    checkOutput("add_valid", 32'(alu_valid), 32'd1);
    checkOutput("add_depth_exec", 32'(depth), 32'd2);
    tick();
    checkOutput("add_top", 32'(top), 32'd8);
    checkOutput("add_depth", 32'(depth), 32'd1);
    checkOutput("add_flags", 32'(flags), 32'h0);
    checkOutput("add_busy_done", 32'(busy), 32'd0);
    checkOutput("add_validcnt", 32'(validCount), 32'd1);

    // 8 - 8 -> zero with carry
    applyStimulus(CMD_PUSH, 16'd8, 2'b00);
    applyStimulus(CMD_OP, 16'd0, 2'b01);
    checkOutput("sub_aluop", 32'(alu_op), 32'd1);
    tick();
    checkOutput("sub_top", 32'(top), 32'd0);
    checkOutput("sub_depth", 32'(depth), 32'd1);
    checkOutput("sub_flags", 32'(flags), 32'h6);

    // Enter during EXEC is ignored
    applyStimulus(CMD_PUSH, 16'h0010, 2'b00);
    applyStimulus(CMD_OP, 16'd0, 2'b00);
    applyStimulus(CMD_PUSH, 16'h0099, 2'b00);
    checkOutput("ign_depth", 32'(depth), 32'd1);
    checkOutput("ign_top", 32'(top), 32'h10);
    checkOutput("ign_error", 32'(error), 32'd0);
    checkOutput("ign_validcnt", 32'(validCount), 32'd3);
    tick();
    checkOutput("ign_depth_later", 32'(depth), 32'd1);

    // Fill to DEPTH then overflow, then DROP clears error
    doReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(CMD_PUSH, 16'(i), 2'b00);
    end
    checkOutput("fill_depth", 32'(depth), 32'd4);
    checkOutput("fill_alua", 32'(alu_a), 32'd3);
    checkOutput("fill_alub", 32'(alu_b), 32'd4);
    applyStimulus(CMD_PUSH, 16'd5, 2'b00);
    checkOutput("ovf_depth", 32'(depth), 32'd4);
    checkOutput("ovf_top", 32'(top), 32'd4);
    checkOutput("ovf_error", 32'(error), 32'd1);
    applyStimulus(CMD_DROP, 16'd0, 2'b00);
    checkOutput("drop_depth", 32'(depth), 32'd3);
    checkOutput("drop_top", 32'(top), 32'd3);
    checkOutput("drop_error", 32'(error), 32'd0);

    // 2 - 3 -> 0xFFFF negative, borrow
    applyStimulus(CMD_OP, 16'd0, 2'b01);
    tick();
    checkOutput("neg_top", 32'(top), 32'hFFFF);
    checkOutput("neg_depth", 32'(depth), 32'd2);
    checkOutput("neg_flags", 32'(flags), 32'h8);

    // Reset during EXEC aborts writeback
    applyStimulus(CMD_OP, 16'd0, 2'b10);
    checkOutput("abort_valid_exec", 32'(alu_valid), 32'd1);
    checkOutput("abort_aluop_exec", 32'(alu_op), 32'd2);
    doReset();
    checkOutput("abort_depth", 32'(depth), 32'd0);
    checkOutput("abort_top", 32'(top), 32'd0);
    checkOutput("abort_flags", 32'(flags), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(alu_valid), 32'd0);
    checkOutput("abort_aluop", 32'(alu_op), 32'd0);

    // DUP
    applyStimulus(CMD_PUSH, 16'd7, 2'b00);
    applyStimulus(CMD_DUP, 16'd0, 2'b00);
`ifdef RPN_STACK_DUP_EN
    checkOutput("dup_depth", 32'(depth), 32'd2);
    checkOutput("dup_top", 32'(top), 32'd7);
    checkOutput("dup_error", 32'(error), 32'd0);
    checkOutput("dup_alua", 32'(alu_a), 32'd7);
`else
    checkOutput("dup_depth", 32'(depth), 32'd1);
    checkOutput("dup_top", 32'(top), 32'd7);
    checkOutput("dup_error", 32'(error), 32'd1);
`endif

    // DROP on empty
    doReset();
    applyStimulus(CMD_DROP, 16'd0, 2'b00);
    checkOutput("dropempty_error", 32'(error), 32'd1);
    checkOutput("dropempty_depth", 32'(depth), 32'd0);
    applyStimulus(CMD_PUSH, 16'd9, 2'b00);
    checkOutput("recover_error", 32'(error), 32'd0);
    checkOutput("recover_top", 32'(top), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
